sdram_cmd_arbiter: RTL and testbench
====================================

# sdram_cmd_arbiter

Parametrised SDRAM command-bus arbiter for N masters (Nios, camera, accelerators, further DMA engines) sharing one SDRAM device. Fixed-priority selection with preemption; every ownership change inserts a drain of NOP cycles, a LOAD MODE REGISTER carrying the incoming master's mode word, and a tMRD settle, so each master sees its own burst/CAS mode. Sits between the per-master SDRAM controllers and the SDRAM pins; owner-grant outputs feed each controller's stall logic.

## Interface
- NUM_MASTERS, 3, number of masters; index 0 highest priority
- ADDR_W, 12, SDRAM address width
- BA_W, 2, bank address width
- CS_W, 2, chip-select width
- DQM_W, 2, data-mask width
- RESET_MASTER, 0, owner immediately after reset
- DEFAULT_MASTER, NUM_MASTERS-1, owner when no request is active
- NOP_CYCLES, 1, drain NOPs before LMR (>=1)
- TMRD, 2, NOP cycles after LMR (>=1)
- MODE_WORDS, {3{12'h030}}, NUM_MASTERS×ADDR_W packed mode words, master m at [m*ADDR_W +: ADDR_W]

- clk  in  1  sole clock; all state on rising edge
- Reset  in  1  synchronous, active-high reset
- req  in  NUM_MASTERS  level request; hold high to keep/obtain ownership
- grant  out  NUM_MASTERS  registered one-hot; bit m = master m has full control
- busy  out  1  registered; 1 while arbiter drives bus (switch in progress)
- sa_m / ba_m / cs_n_m / cke_m / ras_n_m / cas_n_m / we_n_m / dqm_m  in  NUM_MASTERS×field width  packed per-master command buses, master m at slice m
- SA, BA, CS_N, CKE, RAS_N, CAS_N, WE_N, DQM  out  ADDR_W, BA_W, CS_W, 1, 1, 1, 1, DQM_W  SDRAM pins

## Operation
- States: OWN, DRAIN, LMR, SETTLE. Registers: owner, target, cnt.
- Target computation (in OWN, every cycle): lowest index with req high; if req==0, DEFAULT_MASTER.
- OWN: if target==owner stay; else latch target, cnt<=NOP_CYCLES-1, go DRAIN.
- DRAIN: cnt down; at 0 go LMR.
- LMR: one cycle; cnt<=TMRD-1; go SETTLE.
- SETTLE: cnt down; at 0 owner<=target, go OWN.
- req changes during DRAIN/LMR/SETTLE ignored; re-evaluated first OWN cycle after switch (back-to-back switch permitted).
- Owner preempted by any higher-priority request, and by release (req[owner]=0 and some other master or DEFAULT_MASTER selected).
- Bus mux: OWN → all pins from slice owner. DRAIN/SETTLE → NOP: CS_N=0, CKE=1, RAS_N=CAS_N=WE_N=1, DQM all 1, SA=0, BA=0. LMR → CS_N=0, CKE=1, RAS_N=CAS_N=WE_N=0, DQM all 1, BA=0, SA=MODE_WORDS slice target.
- grant = onehot(owner) in OWN, 0 otherwise; busy = !OWN.
- Out-of-range RESET_MASTER/DEFAULT_MASTER: elaboration error.

## Timing
- Reset (synchronous): state OWN, owner=RESET_MASTER, cnt=0; grant=1<<RESET_MASTER, busy=0, pins follow master RESET_MASTER's slice. No LMR issued; SDRAM init is the reset master's job.
- Reset mid-switch: aborts instantly on next edge; LMR never partially issued.
- Switch: req sampled at edge k in OWN → grant=0, busy=1 after edge k; arbiter owns pins for NOP_CYCLES+1+TMRD cycles; new grant after edge k+NOP_CYCLES+1+TMRD (defaults: k+4).
- Pin outputs combinational from registered state and master inputs; no added latency in OWN.
- Simultaneous req from several masters: lowest index wins; others wait.

## Configuration
- ARB_LMR_SKIP_EN defined: if MODE_WORDS slice target equals slice owner, LMR and SETTLE skipped; DRAIN → OWN directly; switch takes NOP_CYCLES cycles.
- Undefined: every switch issues LMR and SETTLE regardless of mode words.

## Test plan
- Reset with NUM_MASTERS=3, RESET_MASTER=0, req=0 → grant=001 during reset; after release, switch to master 2: NOP, LMR SA=MODE_WORDS[2], 2 NOPs, grant=100 at cycle 4.
- In OWN master 2, raise req[1] → grant=000 one cycle later, exactly 1 NOP, 1 LMR (RAS/CAS/WE=0, SA=master-1 word), 2 NOPs, grant=010; pins then track slice 1 bit-exact.
- req=011 simultaneously from master 2 ownership → master 0 wins; req[0] toggled during SETTLE ignored, master 1 granted only after master 0 drops req.
- Assert Reset during LMR → next cycle grant=1<<RESET_MASTER, busy=0, no further LMR.
- Equal mode words for masters 1 and 2, ARB_LMR_SKIP_EN defined → switch 1→2 shows 1 NOP then grant=100; undefined → full 4-cycle sequence with LMR.
- NOP_CYCLES=3, TMRD=1 → exactly 3 NOP, 1 LMR, 1 NOP; DQM all ones throughout busy.

Source files
------------

// File: rtl/sdram_cmd_arbiter.sv
// rtl/sdram_cmd_arbiter.sv - fixed-priority SDRAM command-bus arbiter with NOP/LMR/tMRD ownership switch
// Optional feature macro: ARB_LMR_SKIP_EN (skip LMR and settle when old and new mode words match)
module sdram_cmd_arbiter #(
    parameter int NUM_MASTERS    = 3,
    parameter int ADDR_W         = 12,
    parameter int BA_W           = 2,
    parameter int CS_W           = 2,
    parameter int DQM_W          = 2,
    parameter int RESET_MASTER   = 0,
    parameter int DEFAULT_MASTER = NUM_MASTERS - 1,
    parameter int NOP_CYCLES     = 1,
    parameter int TMRD           = 2,
    parameter logic [NUM_MASTERS*ADDR_W-1:0] MODE_WORDS = {NUM_MASTERS{ADDR_W'(12'h030)}}
) (
    input  logic                          clk_i,
    input  logic                          reset_i,
    input  logic [NUM_MASTERS-1:0]        req_i,
    output logic [NUM_MASTERS-1:0]        grant_o,
    output logic                          busy_o,
    input  logic [NUM_MASTERS*ADDR_W-1:0] sa_m_i,
    input  logic [NUM_MASTERS*BA_W-1:0]   ba_m_i,
    input  logic [NUM_MASTERS*CS_W-1:0]   cs_n_m_i,
    input  logic [NUM_MASTERS-1:0]        cke_m_i,
    input  logic [NUM_MASTERS-1:0]        ras_n_m_i,
    input  logic [NUM_MASTERS-1:0]        cas_n_m_i,
    input  logic [NUM_MASTERS-1:0]        we_n_m_i,
    input  logic [NUM_MASTERS*DQM_W-1:0]  dqm_m_i,
    output logic [ADDR_W-1:0]             sa_o,
    output logic [BA_W-1:0]               ba_o,
    output logic [CS_W-1:0]               cs_n_o,
    output logic                          cke_o,
    output logic                          ras_n_o,
    output logic                          cas_n_o,
    output logic                          we_n_o,
    output logic [DQM_W-1:0]              dqm_o
);

    localparam int OW   = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
    localparam int CMAX = (NOP_CYCLES > TMRD) ? NOP_CYCLES : TMRD;
    localparam int CW   = (CMAX > 1) ? $clog2(CMAX) : 1;

    localparam logic [OW-1:0] RST_OWNER = OW'(RESET_MASTER);
    localparam logic [OW-1:0] DEF_OWNER = OW'(DEFAULT_MASTER);
    localparam logic [CW-1:0] NOP_LOAD  = CW'(NOP_CYCLES - 1);
    localparam logic [CW-1:0] TMRD_LOAD = CW'(TMRD - 1);

    if (RESET_MASTER < 0 || RESET_MASTER >= NUM_MASTERS) begin : g_bad_reset_master
        $error("RESET_MASTER out of range");
    end
    if (DEFAULT_MASTER < 0 || DEFAULT_MASTER >= NUM_MASTERS) begin : g_bad_default_master
        $error("DEFAULT_MASTER out of range");
    end
    if (NOP_CYCLES < 1 || TMRD < 1) begin : g_bad_timing
        $error("NOP_CYCLES and TMRD must be at least 1");
    end

    typedef enum logic [1:0] {S_OWN, S_DRAIN, S_LMR, S_SETTLE} state_t;

    state_t                 state_q, state_d;
    logic [OW-1:0]          owner_q, owner_d;
    logic [OW-1:0]          target_q, target_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [NUM_MASTERS-1:0] grant_q, grant_d;
    logic                   busy_q, busy_d;
    logic [OW-1:0]          req_target;
    logic [ADDR_W-1:0]      mode_target;

    assign mode_target = MODE_WORDS[target_q*ADDR_W +: ADDR_W];

`ifdef ARB_LMR_SKIP_EN
    logic [ADDR_W-1:0] mode_owner;
    assign mode_owner = MODE_WORDS[owner_q*ADDR_W +: ADDR_W];
`endif

    // Priority pick: lowest-index requester wins, idle bus falls back to the default master
    always_comb begin
        req_target = DEF_OWNER;
        for (int m = NUM_MASTERS - 1; m >= 0; m--) begin
            if (req_i[m]) req_target = OW'(m);
        end
    end

    // Arbiter state, owner/target registers, switch counter and registered grant/busy
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q  <= S_OWN;
            owner_q  <= RST_OWNER;
            target_q <= RST_OWNER;
            cnt_q    <= '0;
            grant_q  <= NUM_MASTERS'(1) << RESET_MASTER;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            target_q <= target_d;
            cnt_q    <= cnt_d;
            grant_q  <= grant_d;
            busy_q   <= busy_d;
        end
    end

    // Next-state: requests are only looked at while owned; a switch runs to completion
    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        target_d = target_q;
        cnt_d    = cnt_q;
        case (state_q)
            S_OWN: begin
                if (req_target != owner_q) begin
                    target_d = req_target;
                    cnt_d    = NOP_LOAD;
                    state_d  = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else begin
`ifdef ARB_LMR_SKIP_EN
                    if (mode_target == mode_owner) begin
                        owner_d = target_q;
                        state_d = S_OWN;
                    end else begin
                        state_d = S_LMR;
                    end
`else
                    state_d = S_LMR;
`endif
                end
            end
            S_LMR: begin
                cnt_d   = TMRD_LOAD;
                state_d = S_SETTLE;
            end
            S_SETTLE: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    owner_d = target_q;
                    state_d = S_OWN;
                end
            end
            default: state_d = S_OWN;
        endcase
        grant_d = '0;
        if (state_d == S_OWN) grant_d[owner_d] = 1'b1;
        busy_d = (state_d != S_OWN);
    end

    // Pin mux: owner's slice when owned, NOP while draining/settling, LMR with the incoming mode word
    always_comb begin
        sa_o    = '0;
        ba_o    = '0;
        cs_n_o  = '0;
        cke_o   = 1'b1;
        ras_n_o = 1'b1;
        cas_n_o = 1'b1;
        we_n_o  = 1'b1;
        dqm_o   = '1;
        case (state_q)
            S_OWN: begin
                sa_o    = sa_m_i[owner_q*ADDR_W +: ADDR_W];
                ba_o    = ba_m_i[owner_q*BA_W +: BA_W];
                cs_n_o  = cs_n_m_i[owner_q*CS_W +: CS_W];
                cke_o   = cke_m_i[owner_q];
                ras_n_o = ras_n_m_i[owner_q];
                cas_n_o = cas_n_m_i[owner_q];
                we_n_o  = we_n_m_i[owner_q];
                dqm_o   = dqm_m_i[owner_q*DQM_W +: DQM_W];
            end
            S_LMR: begin
                sa_o    = mode_target;
                ras_n_o = 1'b0;
                cas_n_o = 1'b0;
                we_n_o  = 1'b0;
            end
            default: ;
        endcase
    end

    assign grant_o = grant_q;
    assign busy_o  = busy_q;

endmodule

// File: tb/tb_sdram_cmd_arbiter.sv
// tb/tb_sdram_cmd_arbiter.sv - scoreboard bench for sdram_cmd_arbiter with queue-based switch model
module tb_sdram_cmd_arbiter;

    localparam int NM   = 3;
    localparam int AW   = 12;
    localparam int BW   = 2;
    localparam int CSW  = 2;
    localparam int DW   = 2;
    localparam int RM   = 0;
    localparam int DM   = NM - 1;
    localparam int NOPC = 1;
    localparam int TM   = 2;
    localparam logic [NM*AW-1:0] MW = {12'h022, 12'h022, 12'h031};

    localparam int K_OWN = 0;
    localparam int K_NOP = 1;
    localparam int K_LMR = 2;

    typedef struct {
        int kind;
        int sel;
    } exp_t;

    logic                clk = 1'b0;
    logic                reset = 1'b1;
    logic [NM-1:0]       req = '0;
    logic [NM-1:0]       grant;
    logic                busy;
    logic [NM*AW-1:0]    sa_m = '0;
    logic [NM*BW-1:0]    ba_m = '0;
    logic [NM*CSW-1:0]   cs_n_m = '0;
    logic [NM-1:0]       cke_m = '0;
    logic [NM-1:0]       ras_n_m = '0;
    logic [NM-1:0]       cas_n_m = '0;
    logic [NM-1:0]       we_n_m = '0;
    logic [NM*DW-1:0]    dqm_m = '0;
    logic [AW-1:0]       sa;
    logic [BW-1:0]       ba;
    logic [CSW-1:0]      cs_n;
    logic                cke, ras_n, cas_n, we_n;
    logic [DW-1:0]       dqm;

    logic [NM*AW-1:0]    mw_v = MW;

    int n_checks = 0;
    int n_pass   = 0;

    exp_t exp_q[$];
    exp_t seq[$];
    int   m_owner = RM;
    int   m_target = RM;
    bit   switching = 1'b0;

    sdram_cmd_arbiter #(
        .NUM_MASTERS(NM), .ADDR_W(AW), .BA_W(BW), .CS_W(CSW), .DQM_W(DW),
        .RESET_MASTER(RM), .DEFAULT_MASTER(DM), .NOP_CYCLES(NOPC), .TMRD(TM),
        .MODE_WORDS(MW)
    ) dut (
        .clk_i(clk), .reset_i(reset), .req_i(req), .grant_o(grant), .busy_o(busy),
        .sa_m_i(sa_m), .ba_m_i(ba_m), .cs_n_m_i(cs_n_m), .cke_m_i(cke_m),
        .ras_n_m_i(ras_n_m), .cas_n_m_i(cas_n_m), .we_n_m_i(we_n_m), .dqm_m_i(dqm_m),
        .sa_o(sa), .ba_o(ba), .cs_n_o(cs_n), .cke_o(cke), .ras_n_o(ras_n),
        .cas_n_o(cas_n), .we_n_o(we_n), .dqm_o(dqm)
    );

    always #5 clk = ~clk;

    function automatic logic [AW-1:0] mode_of(input int m);
        return mw_v[m*AW +: AW];
    endfunction

    // Reference model: a switch is a list of bus cycles queued up front, replayed one per clock
    always @(posedge clk) begin
        exp_t e;
        int   t;
        if (reset) begin
            seq.delete();
            switching = 1'b0;
            m_owner = RM;
            e.kind = K_OWN; e.sel = m_owner;
        end else if (switching) begin
            if (seq.size() == 0) begin
                m_owner = m_target;
                switching = 1'b0;
                e.kind = K_OWN; e.sel = m_owner;
            end else begin
                e = seq.pop_front();
            end
        end else begin
            t = DM;
            for (int m = NM - 1; m >= 0; m--) if (req[m]) t = m;
            if (t != m_owner) begin
                exp_t s;
                bit   do_lmr;
                m_target = t;
                do_lmr = 1'b1;
`ifdef ARB_LMR_SKIP_EN
                if (mode_of(t) == mode_of(m_owner)) do_lmr = 1'b0;
`endif
                for (int i = 0; i < NOPC; i++) begin s.kind = K_NOP; s.sel = 0; seq.push_back(s); end
                if (do_lmr) begin
                    s.kind = K_LMR; s.sel = t; seq.push_back(s);
                    for (int i = 0; i < TM; i++) begin s.kind = K_NOP; s.sel = 0; seq.push_back(s); end
                end
                switching = 1'b1;
                e = seq.pop_front();
            end else begin
                e.kind = K_OWN; e.sel = m_owner;
            end
        end
        exp_q.push_back(e);
    end

    // Monitor: pop one expectation per cycle and compare grant/busy and every pin
    always begin
        exp_t e;
        logic [NM-1:0] eg;
        logic          eb;
        logic [21:0]   ep, ap;
        @(posedge clk);
        #1;
        n_checks++;
        if (exp_q.size() == 0) begin
            $display("FAIL scoreboard_empty: no expectation queued at %0t", $time);
        end else begin
            e = exp_q.pop_front();
            eg = '0;
            eb = (e.kind != K_OWN);
            if (e.kind == K_OWN) begin
                eg[e.sel] = 1'b1;
                ep = {sa_m[e.sel*AW +: AW], ba_m[e.sel*BW +: BW], cs_n_m[e.sel*CSW +: CSW],
                      cke_m[e.sel], ras_n_m[e.sel], cas_n_m[e.sel], we_n_m[e.sel],
                      dqm_m[e.sel*DW +: DW]};
            end else if (e.kind == K_LMR) begin
                ep = {mode_of(e.sel), 2'b00, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 2'b11};
            end else begin
                ep = {12'h000, 2'b00, 2'b00, 1'b1, 1'b1, 1'b1, 1'b1, 2'b11};
            end
            ap = {sa, ba, cs_n, cke, ras_n, cas_n, we_n, dqm};
            if (grant !== eg || busy !== eb || ap !== ep) begin
                $display("FAIL cycle_kind%0d_sel%0d at %0t: grant=%b busy=%b pins=%h, required grant=%b busy=%b pins=%h",
                         e.kind, e.sel, $time, grant, busy, ap, eg, eb, ep);
            end else begin
                n_pass++;
            end
        end
    end

    task automatic drive(input logic [NM-1:0] r, input logic rst, input int n);
        repeat (n) begin
            @(negedge clk);
            req     = r;
            reset   = rst;
            sa_m    = (NM*AW)'({$urandom, $urandom});
            ba_m    = (NM*BW)'($urandom);
            cs_n_m  = (NM*CSW)'($urandom);
            cke_m   = NM'($urandom);
            ras_n_m = NM'($urandom);
            cas_n_m = NM'($urandom);
            we_n_m  = NM'($urandom);
            dqm_m   = (NM*DW)'($urandom);
        end
    endtask

    initial begin
        logic [NM-1:0] r;
        // reset, default switch to master 2, preempt by 1, release, simultaneous 011,
        // req[0] toggling during settle, then reset landing on the LMR cycle
        drive(3'b000, 1'b1, 3);
        drive(3'b000, 1'b0, 8);
        drive(3'b010, 1'b0, 8);
        drive(3'b000, 1'b0, 8);
        drive(3'b011, 1'b0, 3);
        drive(3'b010, 1'b0, 1);
        drive(3'b011, 1'b0, 8);
        drive(3'b010, 1'b0, 8);
        drive(3'b001, 1'b0, 2);
        drive(3'b001, 1'b1, 1);
        drive(3'b100, 1'b0, 8);
        drive(3'b010, 1'b0, 8);
        r = '0;
        for (int c = 0; c < 2000; c++) begin
            if ($urandom_range(0, 3) == 0) r = NM'($urandom_range(0, 7));
            drive(r, ($urandom_range(0, 63) == 0), 1);
        end
        drive(r, 1'b0, 2);
        @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
